image_scanner: RTL and testbench
================================

Name: image_scanner

Overview:
Consumes a 32x32-bit image ROM and drives a row-multiplexed LED matrix through a serial column shift-register chain (595-style: sClk/sData/sLatch).
- Scanning one row: drive the ROM address, capture the 32-bit row word, optionally rotate it for horizontal scrolling, shift it out MSB first, latch it, then light that row for a fixed dwell time.
- Sits directly downstream of the image ROM and drives the board's matrix connector.

Parameters:
- ROWS, 8, number of physical matrix rows scanned (ROM rows 0..ROWS-1 used, max 32)
- CLK_DIV, 2, clk cycles per sClk half-period (≥1)
- DWELL, 100, clk cycles a row stays lit (≥1)
- SCROLL_FRAMES, 30, frames between scroll steps (≥1)

Ports:
- clk  in  1  system clock
- rst_n  in  1  asynchronous active-low reset
- enable  in  1  run scanning; sampled only at IDLE and at end of each row
- scrollEn  in  1  advance horizontal scroll offset
- dataRom  in  32  ROM row word, combinational from addRom
- addRom  out  5  ROM row address
- sClk  out  1  shift clock to column chain; data sampled on rising edge
- sData  out  1  serial column data, MSB first
- sLatch  out  1  storage-register latch pulse
- rowSel  out  ROWS  one-hot active-high row enable; all-zero when blank
- frameDone  out  1  one-cycle pulse after the last row's dwell

Behaviour:
- Clock and reset: one clock (clk); reset is asynchronous and active-low (rst_n).
- Reset values: all outputs 0; state=IDLE; row=0; offset=0; frame counter=0. Assertion mid-operation forces this immediately, with no completion of the current row.
- addRom = registered row counter, zero-extended to 5 bits; valid during every state.

States:
- IDLE: outputs blank. If enable=1, go to FETCH next cycle.
- FETCH (1 cycle): shift register ← rotate-left(dataRom, offset).
- SHIFT (64·CLK_DIV cycles): for each bit i=31..0:
  - sData=bit, sClk=0 for CLK_DIV cycles;
  - then sClk=1 for CLK_DIV cycles, with sData held stable.
  - After the last high phase, sClk returns to 0.
- LATCH (CLK_DIV cycles): sLatch=1, sClk=0.
- DISPLAY (DWELL cycles): rowSel=1<<row.
- End of DISPLAY:
  - If row==ROWS-1: row←0, frameDone=1 for one cycle, frame counter++.
  - Otherwise: row++.
  - Then: enable=1 → FETCH; enable=0 → IDLE.
- Blanking: rowSel=0 in every state except DISPLAY (anti-ghosting).

Timing:
- Row period = 1 + 65·CLK_DIV + DWELL cycles (231 at defaults).
- Frame = ROWS·row period.

Scroll:
- At frame end, if scrollEn=1 and the frame counter reaches SCROLL_FRAMES-1, the counter resets to 0 and offset increments mod 32 (31→0).
- If scrollEn=0, offset holds and the frame counter holds at 0.
- Offset changes only at frame boundaries; it is never mid-frame.

Boundary conditions:
- enable deasserted mid-row: current row completes through DISPLAY, then IDLE. Row counter is retained; resume continues at the next row.
- frameDone and a scroll step occur in the same cycle.

Decomposition:
Package image_pkg holds:
- ROM_W=32, ADDR_W=5
- state enum {IDLE, FETCH, SHIFT, LATCH, DISPLAY}
- rotl32 function

One sub-module, serial_shifter:
- Loads a 32-bit word and runs the divided sClk/sData sequence.
- Raises done when finished.
- The top-level FSM handles row, dwell, latch and scroll.

Test Plan:
- Reset: hold rst_n=0 → all outputs 0. Assert rst_n=0 async during SHIFT → sClk, sData and rowSel drop to 0 before the next clk edge; after release, scanning restarts at addRom=0.
- Single row, row 0 word 32'hFFFFFF00, offset 0, CLK_DIV=2:
  - sampled sData on 32 sClk rises = 24 ones then 8 zeros;
  - sLatch high 2 cycles, then rowSel=8'b00000001 for exactly 100 cycles;
  - row period 231 cycles.
- Full frame, ROWS=8:
  - addRom steps 0..7 and wraps to 0;
  - rowSel walks one-hot bit0..bit7;
  - frameDone pulses exactly once per 1848 cycles.
- Scroll, SCROLL_FRAMES=1, scrollEn=1, row word 32'h80000001:
  - frame 1 shifts 32'h80000001;
  - frame 2 shifts 32'h00000003;
  - after 32 frames the pattern returns to the original.
- enable dropped during SHIFT of row 3:
  - row 3 completes its DISPLAY, then IDLE with rowSel=0;
  - re-enable → FETCH with addRom=4.
- Blanking check: rowSel=0 throughout every FETCH, SHIFT and LATCH interval over a full frame.

Source files
------------

// File: rtl/image_scanner_pkg.sv
// Shared widths, scan FSM states and the row-word rotate helper for the LED matrix scanner.
package image_pkg;
    localparam int ROM_W  = 32;
    localparam int ADDR_W = 5;

    typedef enum logic [2:0] {IDLE, FETCH, SHIFT, LATCH, DISPLAY} state_t;

    // Upper half of the doubled word shifted left is the rotate-left result.
    function automatic logic [ROM_W-1:0] rotl32(input logic [ROM_W-1:0] w, input logic [ADDR_W-1:0] n);
        logic [2*ROM_W-1:0] d;
        d = {w, w} << n;
        return d[2*ROM_W-1:ROM_W];
    endfunction
endpackage

// File: rtl/image_scanner_serial_shifter.sv
// Serialises a 32-bit row word MSB first onto a divided sClk; done flags the final clk cycle of the sequence.
module serial_shifter
    import image_pkg::*;
#(
    parameter int CLK_DIV = 2
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             load,
    input  logic [ROM_W-1:0] word,
    output logic             sclk,
    output logic             sdata,
    output logic             done
);
    localparam int DW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

    logic             busy;
    logic             phase;
    logic [DW-1:0]    div;
    logic [4:0]       bitn;
    logic [ROM_W-1:0] sreg;
    logic             tick;

    assign tick  = (div == DW'(CLK_DIV - 1));
    assign done  = busy & tick & phase & (bitn == 5'd31);
    // The MSB of the shift register is the line itself, so sData stays flop-driven.
    assign sdata = sreg[ROM_W-1];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            busy  <= 1'b0;
            phase <= 1'b0;
            div   <= '0;
            bitn  <= '0;
            sreg  <= '0;
            sclk  <= 1'b0;
        end else if (load) begin
            busy  <= 1'b1;
            phase <= 1'b0;
            div   <= '0;
            bitn  <= '0;
            sreg  <= word;
            sclk  <= 1'b0;
        end else if (busy) begin
            if (!tick) begin
                div <= div + 1'b1;
            end else begin
                div <= '0;
                if (!phase) begin
                    phase <= 1'b1;
                    sclk  <= 1'b1;
                end else begin
                    phase <= 1'b0;
                    sclk  <= 1'b0;
                    if (bitn == 5'd31) begin
                        busy <= 1'b0;
                        sreg <= '0;
                    end else begin
                        bitn <= bitn + 1'b1;
                        sreg <= {sreg[ROM_W-2:0], 1'b0};
                    end
                end
            end
        end
    end
endmodule

// File: rtl/image_scanner.sv
// Row-multiplexed LED matrix scanner: fetches each ROM row, shifts it to the column chain, latches, then lights the row.
module image_scanner
    import image_pkg::*;
#(
    parameter int ROWS          = 8,
    parameter int CLK_DIV       = 2,
    parameter int DWELL         = 100,
    parameter int SCROLL_FRAMES = 30
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              enable,
    input  logic              scrollEn,
    input  logic [ROM_W-1:0]  dataRom,
    output logic [ADDR_W-1:0] addRom,
    output logic              sClk,
    output logic              sData,
    output logic              sLatch,
    output logic [ROWS-1:0]   rowSel,
    output logic              frameDone
);
    localparam int RW   = (ROWS > 1) ? $clog2(ROWS) : 1;
    localparam int CMAX = (DWELL > CLK_DIV) ? DWELL : CLK_DIV;
    localparam int CW   = (CMAX > 1) ? $clog2(CMAX) : 1;
    localparam int FW   = (SCROLL_FRAMES > 1) ? $clog2(SCROLL_FRAMES) : 1;

    state_t            state;
    logic [RW-1:0]     row;
    logic [ADDR_W-1:0] offset;
    logic [FW-1:0]     fcnt;
    logic [CW-1:0]     cnt;
    logic              load;
    logic              sh_done;
    logic [ROM_W-1:0]  word;

    assign addRom = ADDR_W'(row);
    assign load   = (state == FETCH);
    assign word   = rotl32(dataRom, offset);

    serial_shifter #(.CLK_DIV(CLK_DIV)) u_shifter (
        .clk   (clk),
        .rst_n (rst_n),
        .load  (load),
        .word  (word),
        .sclk  (sClk),
        .sdata (sData),
        .done  (sh_done)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            row       <= '0;
            offset    <= '0;
            fcnt      <= '0;
            cnt       <= '0;
            sLatch    <= 1'b0;
            rowSel    <= '0;
            frameDone <= 1'b0;
        end else begin
            frameDone <= 1'b0;
            case (state)
                IDLE:  if (enable) state <= FETCH;
                FETCH: state <= SHIFT;
                SHIFT: if (sh_done) begin
                    state  <= LATCH;
                    sLatch <= 1'b1;
                    cnt    <= '0;
                end
                LATCH: if (cnt == CW'(CLK_DIV - 1)) begin
                    state  <= DISPLAY;
                    sLatch <= 1'b0;
                    rowSel <= ROWS'(1) << row;
                    cnt    <= '0;
                end else begin
                    cnt <= cnt + 1'b1;
                end
                DISPLAY: if (cnt == CW'(DWELL - 1)) begin
                    // Rows are blanked before the next shift so old columns never ghost.
                    rowSel <= '0;
                    cnt    <= '0;
                    state  <= enable ? FETCH : IDLE;
                    if (row == RW'(ROWS - 1)) begin
                        row       <= '0;
                        frameDone <= 1'b1;
                        if (!scrollEn) begin
                            fcnt <= '0;
                        end else if (fcnt == FW'(SCROLL_FRAMES - 1)) begin
                            fcnt   <= '0;
                            offset <= offset + 1'b1;
                        end else begin
                            fcnt <= fcnt + 1'b1;
                        end
                    end else begin
                        row <= row + 1'b1;
                    end
                end else begin
                    cnt <= cnt + 1'b1;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_image_scanner.sv
// Bench for image_scanner: random ROM contents, an output-side monitor and a frame/offset reference model.
module tb_image_scanner;
    localparam int ROWS    = 8;
    localparam int CLK_DIV = 2;
    localparam int DWELL   = 100;
    localparam int SF      = 1;
    localparam int ROW_P   = 1 + 65 * CLK_DIV + DWELL;

    logic            clk = 1'b0;
    logic            rst_n = 1'b1;
    logic            enable = 1'b0;
    logic            scrollEn = 1'b0;
    logic [31:0]     dataRom;
    logic [4:0]      addRom;
    logic            sClk, sData, sLatch, frameDone;
    logic [ROWS-1:0] rowSel;
    logic [31:0]     rom [32];

    int errors = 0, checks = 0, cyc = 0;
    logic p_sclk = 1'b0, p_sdata = 1'b0, p_latch = 1'b0, p_fd = 1'b0;
    logic [31:0] cap = '0;
    int nb = 0, lat_len = 0, run_len = 0, fd_hi = 0, blank_viol = 0, stab_viol = 0;
    logic [ROWS-1:0] run_val = '0;
    logic [31:0] words_q[$];
    logic [ROWS-1:0] runval_q[$];
    int nbits_q[$], addr_q[$], latcyc_q[$], latlen_q[$], runlen_q[$], fd_q[$];

    assign dataRom = rom[addRom];

    image_scanner #(.ROWS(ROWS), .CLK_DIV(CLK_DIV), .DWELL(DWELL), .SCROLL_FRAMES(SF)) dut (
        .clk(clk), .rst_n(rst_n), .enable(enable), .scrollEn(scrollEn), .dataRom(dataRom),
        .addRom(addRom), .sClk(sClk), .sData(sData), .sLatch(sLatch), .rowSel(rowSel),
        .frameDone(frameDone)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] ref_rot(logic [31:0] w, int k);
        logic [31:0] r = w;
        for (int i = 0; i < k; i++) r = {r[30:0], r[31]};
        return r;
    endfunction

    // Advance one clock and record what the matrix connector did in that cycle.
    task automatic step();
        @(posedge clk);
        #1;
        cyc++;
        if (sClk && !p_sclk) begin cap = {cap[30:0], sData}; nb++; end
        if (sClk && p_sclk && sData !== p_sdata) stab_viol++;
        if (sLatch && !p_latch) begin
            words_q.push_back(cap); nbits_q.push_back(nb); addr_q.push_back(int'(addRom));
            latcyc_q.push_back(cyc); cap = '0; nb = 0; lat_len = 0;
        end
        if (sLatch) lat_len++;
        if (!sLatch && p_latch) latlen_q.push_back(lat_len);
        if (rowSel != '0) begin
            if (run_len == 0) run_val = rowSel;
            run_len++;
            if (sClk || sLatch || rowSel != run_val || !$onehot(rowSel)) blank_viol++;
        end else if (run_len != 0) begin
            runval_q.push_back(run_val); runlen_q.push_back(run_len); run_len = 0;
        end
        if (frameDone) begin fd_hi++; if (!p_fd) fd_q.push_back(cyc); end
        p_sclk = sClk; p_sdata = sData; p_latch = sLatch; p_fd = frameDone;
    endtask

    task automatic clr_mon();
        words_q.delete(); runval_q.delete(); nbits_q.delete(); addr_q.delete();
        latcyc_q.delete(); latlen_q.delete(); runlen_q.delete(); fd_q.delete();
        cap = '0; nb = 0; run_len = 0; fd_hi = 0; blank_viol = 0; stab_viol = 0;
    endtask

    task automatic test_reset();
        #1 rst_n = 1'b0;
        repeat (3) step();
        checks++; if (sClk !== 1'b0) begin errors++; $display("FAIL reset_sclk got=%b want=0", sClk); end
        checks++; if (sData !== 1'b0) begin errors++; $display("FAIL reset_sdata got=%b want=0", sData); end
        checks++; if (sLatch !== 1'b0) begin errors++; $display("FAIL reset_slatch got=%b want=0", sLatch); end
        checks++; if (rowSel !== '0) begin errors++; $display("FAIL reset_rowsel got=%b want=0", rowSel); end
        checks++; if (frameDone !== 1'b0) begin errors++; $display("FAIL reset_framedone got=%b want=0", frameDone); end
        checks++; if (addRom !== 5'd0) begin errors++; $display("FAIL reset_addrom got=%0d want=0", addRom); end
        @(negedge clk) rst_n = 1'b1;
        clr_mon();
        repeat (5) step();
        checks++; if (sClk !== 1'b0 || rowSel !== '0 || sLatch !== 1'b0) begin
            errors++; $display("FAIL idle_quiet got sclk=%b latch=%b rowsel=%b want all 0", sClk, sLatch, rowSel);
        end
    endtask

    task automatic test_single_row();
        rom[0] = 32'hFFFFFF00;
        clr_mon();
        enable = 1'b1;
        for (int i = 0; i < 800 && (latcyc_q.size() < 2 || runlen_q.size() < 1); i++) step();
        checks++; if (latcyc_q.size() < 2) begin errors++; $display("FAIL row_timeout got=%0d latches want=2", latcyc_q.size()); end
        checks++; if (words_q[0] !== 32'hFFFFFF00) begin errors++; $display("FAIL row0_word got=%h want=ffffff00", words_q[0]); end
        checks++; if (nbits_q[0] != 32) begin errors++; $display("FAIL row0_bits got=%0d want=32", nbits_q[0]); end
        checks++; if (latlen_q[0] != CLK_DIV) begin errors++; $display("FAIL row0_latch_len got=%0d want=%0d", latlen_q[0], CLK_DIV); end
        checks++; if (runval_q[0] !== 8'b00000001) begin errors++; $display("FAIL row0_rowsel got=%b want=00000001", runval_q[0]); end
        checks++; if (runlen_q[0] != DWELL) begin errors++; $display("FAIL row0_dwell got=%0d want=%0d", runlen_q[0], DWELL); end
        checks++; if (latcyc_q[1] - latcyc_q[0] != ROW_P) begin
            errors++; $display("FAIL row_period got=%0d want=%0d", latcyc_q[1] - latcyc_q[0], ROW_P);
        end
    endtask

    task automatic test_full_frame();
        int bad_len = 0;
        for (int i = 0; i < 2 * ROWS * ROW_P + 400 && fd_q.size() < 2; i++) step();
        checks++; if (fd_q.size() < 2) begin errors++; $display("FAIL frame_timeout got=%0d pulses want=2", fd_q.size()); end
        checks++; if (fd_q[1] - fd_q[0] != ROWS * ROW_P) begin
            errors++; $display("FAIL frame_period got=%0d want=%0d", fd_q[1] - fd_q[0], ROWS * ROW_P);
        end
        checks++; if (fd_hi != 2) begin errors++; $display("FAIL framedone_width got=%0d high cycles want=2", fd_hi); end
        for (int r = 0; r < ROWS; r++) begin
            checks++; if (addr_q[r] != r) begin errors++; $display("FAIL frame_addr[%0d] got=%0d want=%0d", r, addr_q[r], r); end
            checks++; if (runval_q[r] !== ROWS'(1 << r)) begin errors++; $display("FAIL frame_rowsel[%0d] got=%b want bit %0d", r, runval_q[r], r); end
            checks++; if (words_q[r] !== rom[r]) begin errors++; $display("FAIL frame_word[%0d] got=%h want=%h", r, words_q[r], rom[r]); end
        end
        checks++; if (addr_q[ROWS] != 0) begin errors++; $display("FAIL frame_wrap got=%0d want=0", addr_q[ROWS]); end
        foreach (runlen_q[i]) if (runlen_q[i] != DWELL) bad_len++;
        foreach (latlen_q[i]) if (latlen_q[i] != CLK_DIV) bad_len++;
        foreach (nbits_q[i]) if (i > 0 && nbits_q[i] != 32) bad_len++;
        checks++; if (bad_len != 0) begin errors++; $display("FAIL frame_lengths got=%0d bad intervals want=0", bad_len); end
        checks++; if (blank_viol != 0) begin errors++; $display("FAIL blanking got=%0d violations want=0", blank_viol); end
        checks++; if (stab_viol != 0) begin errors++; $display("FAIL sdata_stable got=%0d violations want=0", stab_viol); end
    endtask

    task automatic test_enable_drop();
        for (int i = 0; i < 3000 && !(addRom == 5'd3 && sClk); i++) step();
        checks++; if (!(addRom == 5'd3 && sClk)) begin errors++; $display("FAIL drop_timeout got addr=%0d want row 3 shifting", addRom); end
        enable = 1'b0;
        clr_mon();
        repeat (300) step();
        checks++; if (runval_q.size() != 1 || runval_q[0] !== 8'h08) begin
            errors++; $display("FAIL drop_row3 got=%0d runs first=%b want 1 run 00001000", runval_q.size(), runval_q[0]);
        end
        checks++; if (runlen_q[0] != DWELL) begin errors++; $display("FAIL drop_dwell got=%0d want=%0d", runlen_q[0], DWELL); end
        checks++; if (rowSel !== '0 || sClk !== 1'b0 || latcyc_q.size() != 1) begin
            errors++; $display("FAIL drop_idle got rowsel=%b sclk=%b latches=%0d want 0/0/1", rowSel, sClk, latcyc_q.size());
        end
        checks++; if (addRom !== 5'd4) begin errors++; $display("FAIL drop_addr got=%0d want=4", addRom); end
        enable = 1'b1;
        clr_mon();
        for (int i = 0; i < 400 && runval_q.size() < 1; i++) step();
        checks++; if (addr_q[0] != 4 || words_q[0] !== rom[4]) begin
            errors++; $display("FAIL resume_row got addr=%0d word=%h want 4 %h", addr_q[0], words_q[0], rom[4]);
        end
        checks++; if (runval_q[0] !== 8'h10) begin errors++; $display("FAIL resume_rowsel got=%b want=00010000", runval_q[0]); end
    endtask

    task automatic test_scroll();
        rom[0] = 32'h80000001;
        clr_mon();
        for (int i = 0; i < 2500 && fd_q.size() == 0; i++) step();
        checks++; if (fd_q.size() == 0) begin errors++; $display("FAIL scroll_sync got=0 pulses want=1"); end
        scrollEn = 1'b1;
        for (int f = 0; f <= 32; f++) begin
            clr_mon();
            for (int i = 0; i < ROWS * ROW_P + 100 && fd_q.size() == 0; i++) step();
            checks++; if (words_q.size() != ROWS || fd_hi != 1) begin
                errors++; $display("FAIL scroll_frame%0d got words=%0d fd=%0d want %0d/1", f, words_q.size(), fd_hi, ROWS);
            end
            for (int r = 0; r < ROWS; r++) begin
                logic [31:0] exp_w;
                exp_w = ref_rot(rom[r], (f / SF) % 32);
                checks++; if (words_q[r] !== exp_w) begin
                    errors++; $display("FAIL scroll_word f%0d r%0d got=%h want=%h", f, r, words_q[r], exp_w);
                end
            end
        end
    endtask

    task automatic test_async_reset();
        scrollEn = 1'b0;
        for (int i = 0; i < 32; i++) rom[i] = 32'hFFFFFFFF;
        for (int i = 0; i < 2000 && !(sClk && sData); i++) step();
        checks++; if (!(sClk && sData)) begin errors++; $display("FAIL areset_sync got sclk=%b sdata=%b want 1/1", sClk, sData); end
        #2 rst_n = 1'b0;
        #1;
        checks++; if (sClk !== 1'b0 || sData !== 1'b0) begin
            errors++; $display("FAIL areset_serial got sclk=%b sdata=%b want 0/0", sClk, sData);
        end
        checks++; if (rowSel !== '0 || sLatch !== 1'b0 || addRom !== 5'd0) begin
            errors++; $display("FAIL areset_rest got rowsel=%b latch=%b addr=%0d want 0", rowSel, sLatch, addRom);
        end
        rom[0] = 32'h00000001 | ($urandom & 32'h7FFFFFF0);
        repeat (2) step();
        @(negedge clk) rst_n = 1'b1;
        clr_mon();
        for (int i = 0; i < 800 && words_q.size() == 0; i++) step();
        checks++; if (addr_q[0] != 0 || words_q[0] !== rom[0]) begin
            errors++; $display("FAIL areset_restart got addr=%0d word=%h want 0 %h", addr_q[0], words_q[0], rom[0]);
        end
    endtask

    initial begin
        for (int i = 0; i < 32; i++) rom[i] = $urandom;
        test_reset();
        test_single_row();
        test_full_frame();
        test_enable_drop();
        test_scroll();
        test_async_reset();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
